// File: rtl/wind_tx_pkg.sv
// Shared constants, FSM encoding and sample payload for the wind telemetry transmitter.
package wind_tx_pkg;

    localparam int unsigned FRAME_LEN = 11;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned SAMPLE_W  = 16;

    localparam int unsigned IDX_SYNC = 0;
    localparam int unsigned IDX_SEQ  = 1;
    localparam int unsigned IDX_CHK  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } tx_state_t;

    // Samples frozen at frame start.
    typedef struct packed {
        logic [SAMPLE_W-1:0] windspeed;
        logic [SAMPLE_W-1:0] windangle;
        logic [SAMPLE_W-1:0] speed_x;
        logic [SAMPLE_W-1:0] speed_y;
    } sample_t;

endpackage

// File: rtl/wind_telemetry_tx.sv
// Captures wind samples on a (decimated) strobe and streams an 11-byte frame over the UART byte handshake.
module wind_telemetry_tx
    import wind_tx_pkg::*;
#(
    parameter logic [7:0]  FRAME_SYNC = 8'hA5,
    parameter int unsigned DECIM_W    = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [DECIM_W-1:0] decim,
    input  logic               start,
    input  logic [15:0]        windspeed,
    input  logic [15:0]        windangle,
    input  logic [15:0]        speedX,
    input  logic [15:0]        speedY,
    input  logic               txready,
    output logic               txen,
    output logic [7:0]         dataout,
    output logic               busy,
    output logic [7:0]         dropped
);

    localparam logic [IDX_W-1:0] SYNC_IDX = IDX_W'(IDX_SYNC);
    localparam logic [IDX_W-1:0] SEQ_IDX  = IDX_W'(IDX_SEQ);
    localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(IDX_CHK);

    tx_state_t          state;
    sample_t            cap;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         seq;
    logic [7:0]         acc;
    logic [DECIM_W-1:0] dcnt;
    logic [7:0]         byte_c;
    logic               strobe_c;

    assign strobe_c = start & enable;

    // Byte selection for the current frame position; checksum byte is the negated running sum.
    always_comb begin
        byte_c = 8'h00;
        case (idx)
            SYNC_IDX:       byte_c = FRAME_SYNC;
            SEQ_IDX:        byte_c = seq;
            IDX_W'(2):      byte_c = cap.windspeed[15:8];
            IDX_W'(3):      byte_c = cap.windspeed[7:0];
            IDX_W'(4):      byte_c = cap.windangle[15:8];
            IDX_W'(5):      byte_c = cap.windangle[7:0];
            IDX_W'(6):      byte_c = cap.speed_x[15:8];
            IDX_W'(7):      byte_c = cap.speed_x[7:0];
            IDX_W'(8):      byte_c = cap.speed_y[15:8];
            IDX_W'(9):      byte_c = cap.speed_y[7:0];
            CHK_IDX:        byte_c = ~acc + 8'd1;
            default:        byte_c = 8'h00;
        endcase
    end

    // Saturating count of enabled strobes that arrive while a frame is in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dropped <= 8'h00;
        end else if (strobe_c && (state != IDLE) && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
        end
    end

    // Frame sequencer: capture/decimate in IDLE, one byte per SEND, one ignore-ready GUARD cycle after each.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cap     <= '0;
            idx     <= '0;
            seq     <= 8'h00;
            acc     <= 8'h00;
            dcnt    <= '0;
            txen    <= 1'b0;
            dataout <= 8'h00;
            busy    <= 1'b0;
        end else begin
            txen <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe_c) begin
                        if (dcnt == '0) begin
                            cap   <= '{windspeed: windspeed, windangle: windangle,
                                       speed_x: speedX, speed_y: speedY};
                            dcnt  <= decim;
                            idx   <= '0;
                            acc   <= 8'h00;
                            busy  <= 1'b1;
                            state <= SEND;
                        end else begin
                            dcnt <= dcnt - DECIM_W'(1);
                        end
                    end
                end
                SEND: begin
                    if (txready) begin
                        txen    <= 1'b1;
                        dataout <= byte_c;
                        if ((idx != SYNC_IDX) && (idx != CHK_IDX)) begin
                            acc <= acc + byte_c;
                        end
                        state <= GUARD;
                    end
                end
                GUARD: begin
                    if (idx == CHK_IDX) begin
                        seq   <= seq + 8'd1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= SEND;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
            if (!enable) begin
                dcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wind_telemetry_tx.sv
// Self-checking bench: frame-level reference model compared against the transmitter every cycle.
module tb_wind_telemetry_tx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  decim = 8'd0;
    logic        start = 1'b0;
    logic [15:0] windspeed = 16'd0;
    logic [15:0] windangle = 16'd0;
    logic [15:0] speedX = 16'd0;
    logic [15:0] speedY = 16'd0;
    logic        txready = 1'b0;
    logic        txen;
    logic [7:0]  dataout;
    logic        busy;
    logic [7:0]  dropped;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_busy = 1'b0;
    logic       m_guard = 1'b0;
    logic [7:0] m_seq = 8'd0;
    int         m_dcnt = 0;
    int         m_drop = 0;
    logic       m_txen = 1'b0;
    logic [7:0] m_data = 8'd0;

    // Bytes observed on the DUT handshake
    logic [7:0] rx[$];

    always #5 clock = ~clock;

    wind_telemetry_tx #(.FRAME_SYNC(8'hA5), .DECIM_W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .decim     (decim),
        .start     (start),
        .windspeed (windspeed),
        .windangle (windangle),
        .speedX    (speedX),
        .speedY    (speedY),
        .txready   (txready),
        .txen      (txen),
        .dataout   (dataout),
        .busy      (busy),
        .dropped   (dropped)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame content straight from the byte layout; checksum makes bytes 1..10 sum to 0 mod 256.
    function automatic void build_frame(input logic [7:0] s, input logic [15:0] sp, input logic [15:0] an,
                                        input logic [15:0] x, input logic [15:0] y, output logic [7:0] f[11]);
        int sum;
        f[0] = 8'hA5; f[1] = s;
        f[2] = sp[15:8]; f[3] = sp[7:0];
        f[4] = an[15:8]; f[5] = an[7:0];
        f[6] = x[15:8];  f[7] = x[7:0];
        f[8] = y[15:8];  f[9] = y[7:0];
        sum = 0;
        for (int i = 1; i <= 9; i++) sum += int'(f[i]);
        f[10] = 8'((256 - (sum % 256)) % 256);
    endfunction

    function automatic logic [7:0] rxb(input int i);
        if (i < rx.size()) return rx[i];
        return 8'hxx;
    endfunction

    // Model: one step per clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [7:0] f[11];
        logic acc;
        acc = start && enable;
        m_txen = 1'b0;
        if (!m_busy) begin
            if (acc) begin
                if (m_dcnt == 0) begin
                    build_frame(m_seq, windspeed, windangle, speedX, speedY, f);
                    m_q.delete();
                    for (int i = 0; i < 11; i++) m_q.push_back(f[i]);
                    m_busy = 1'b1;
                    m_guard = 1'b0;
                    m_dcnt = int'(decim);
                end else begin
                    m_dcnt = m_dcnt - 1;
                end
            end
        end else begin
            if (acc && m_drop < 255) m_drop = m_drop + 1;
            if (m_guard) begin
                m_guard = 1'b0;
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_seq = m_seq + 8'd1;
                end
            end else if (txready) begin
                m_txen = 1'b1;
                m_data = m_q.pop_front();
                m_guard = 1'b1;
            end
        end
        if (!enable) m_dcnt = 0;
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                m_busy = 1'b0; m_guard = 1'b0; m_seq = 8'd0; m_dcnt = 0;
                m_drop = 0; m_txen = 1'b0; m_data = 8'd0;
            end else begin
                model_step();
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            chk("txen", 32'(txen), 32'(m_txen));
            chk("dataout", 32'(dataout), 32'(m_data));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("dropped", 32'(dropped), 32'(m_drop));
            if (txen === 1'b1) rx.push_back(dataout);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [15:0] sp, input logic [15:0] an, input logic [15:0] x, input logic [15:0] y);
        start = 1'b1; windspeed = sp; windangle = an; speedX = x; speedY = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy !== 1'b0; i++) tick();
        chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] f[11];
        logic [7:0] basic_exp[11];
        int n_before;

        // Reset state
        tick(); tick();
        chk("rst_txen", 32'(txen), 32'(0));
        chk("rst_dataout", 32'(dataout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_dropped", 32'(dropped), 32'(0));
        reset_n = 1'b1;
        tick();

        // Pin the frame builder against the hand-computed checksum
        build_frame(8'h00, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, f);
        chk("model_chk", 32'(f[10]), 32'h40);

        // Basic frame
        enable = 1'b1; decim = 8'd0; txready = 1'b1;
        rx.delete();
        strobe(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF);
        wait_idle(100);
        basic_exp = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h40};
        chk("basic_len", 32'(rx.size()), 32'(11));
        for (int i = 0; i < 11; i++) chk($sformatf("basic_b%0d", i), 32'(rxb(i)), 32'(basic_exp[i]));

        // Decimation and sequence numbering
        do_reset();
        enable = 1'b1; decim = 8'd2; txready = 1'b1;
        rx.delete();
        for (int k = 0; k < 9; k++) begin
            strobe(16'h1000 + 16'(k), 16'h2222, 16'h3333, 16'h4444);
            for (int j = 0; j < 40; j++) tick();
        end
        chk("decim_len", 32'(rx.size()), 32'(33));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("decim_seq%0d", k), 32'(rxb(11 * k + 1)), 32'(k));
            chk($sformatf("decim_spd%0d", k), 32'(rxb(11 * k + 3)), 32'(3 * k));
        end

        // Backpressure before byte 3
        decim = 8'd0;
        rx.delete();
        strobe(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        for (int i = 0; i < 100 && rx.size() < 3; i++) tick();
        txready = 1'b0;
        n_before = rx.size();
        for (int i = 0; i < 50; i++) tick();
        chk("stall_no_txen", 32'(rx.size()), 32'(n_before));
        txready = 1'b1;
        wait_idle(100);
        chk("bp_len", 32'(rx.size()), 32'(11));
        chk("bp_seq", 32'(rxb(1)), 32'h03);
        chk("bp_b2", 32'(rxb(2)), 32'h12);
        chk("bp_b3", 32'(rxb(3)), 32'h34);

        // Drops during a long stalled frame
        rx.delete();
        txready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            start = 1'b1;
            windspeed = (i == 0) ? 16'hBEEF : 16'(i);
            windangle = 16'(i); speedX = 16'(i); speedY = 16'(i);
            tick();
        end
        start = 1'b0;
        chk("drop_sat", 32'(dropped), 32'd255);
        txready = 1'b1;
        wait_idle(100);
        chk("drop_len", 32'(rx.size()), 32'(11));
        chk("drop_b2", 32'(rxb(2)), 32'hBE);
        chk("drop_b3", 32'(rxb(3)), 32'hEF);
        chk("drop_b5", 32'(rxb(5)), 32'h00);

        // Enable dropped mid-frame: frame completes, later strobes ignored
        rx.delete();
        strobe(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        tick(); tick(); tick();
        enable = 1'b0;
        wait_idle(100);
        chk("en_off_len", 32'(rx.size()), 32'(11));
        for (int i = 0; i < 5; i++) begin
            strobe(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            tick(); tick();
        end
        for (int i = 0; i < 30; i++) tick();
        chk("en_off_quiet", 32'(rx.size()), 32'(11));

        // Reset mid-frame, then next frame restarts at seq 0
        enable = 1'b1;
        rx.delete();
        strobe(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        for (int i = 0; i < 100 && rx.size() < 4; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_txen", 32'(txen), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_drop", 32'(dropped), 32'(0));
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        rx.delete();
        strobe(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        wait_idle(100);
        chk("post_rst_len", 32'(rx.size()), 32'(11));
        chk("post_rst_sync", 32'(rxb(0)), 32'hA5);
        chk("post_rst_seq", 32'(rxb(1)), 32'h00);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 15) != 0);
            txready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) decim = 8'($urandom_range(0, 3));
            windspeed = 16'($urandom); windangle = 16'($urandom);
            speedX = 16'($urandom); speedY = 16'($urandom);
            if ($urandom_range(0, 1499) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            tick();
        end
        reset_n = 1'b1;
        start = 1'b0;
        txready = 1'b1;
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
